// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data requests win.
// Optional ARB_TIMEOUT_EN macro adds a per-transaction busy timeout and sticky err flag.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_busy,
    output logic              stall,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    logic [1:0] state_reg;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Freeze the core while any request has not yet been acknowledged.
    assign stall = (i_req & ~i_ack) | ((d_read | d_write) & ~d_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_data    <= NOP;
            d_rdata   <= '0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (d_read | d_write) begin
                        // A store wins when both read and write are raised.
                        state_reg <= DATA;
                        bus_write <= d_write;
                        bus_read  <= ~d_write;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        bus_sel   <= d_sel;
`ifdef ARB_TIMEOUT_EN
                        cnt_reg   <= '0;
`endif
                    end else if (i_req) begin
                        state_reg <= FETCH;
                        bus_read  <= 1'b1;
                        bus_write <= 1'b0;
                        bus_addr  <= i_addr;
                        bus_sel   <= 4'hF;
`ifdef ARB_TIMEOUT_EN
                        cnt_reg   <= '0;
`endif
                    end
                end
                FETCH, DATA: begin
                    if (!bus_busy) begin
                        state_reg <= DONE;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        if (state_reg == FETCH) begin
                            i_ack  <= 1'b1;
                            i_data <= bus_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (bus_read) begin
                                d_rdata <= bus_rdata;
                            end
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // The busy cycle that brings the count to TIMEOUT abandons the access.
                    else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg <= DONE;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        err_reg   <= 1'b1;
                        if (state_reg == FETCH) begin
                            i_ack  <= 1'b1;
                            i_data <= NOP;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected acks into a queue,
// a negedge monitor pops and compares kind, data and arrival cycle.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_data;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_sel = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata = '0;
    logic        bus_busy = 1'b0;
    logic        stall;
    logic        err;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_data   (i_data),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_sel    (d_sel),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .bus_read (bus_read),
        .bus_write(bus_write),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_sel  (bus_sel),
        .bus_rdata(bus_rdata),
        .bus_busy (bus_busy),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_ack(input bit is_data, input bit chk_data, input logic [31:0] data,
                              input int at_cyc);
        exp_t e;
        e.is_data  = is_data;
        e.chk_data = chk_data;
        e.data     = data;
        e.cyc      = at_cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack consumes one expectation.
    always @(negedge clk) begin
        if (!rst && (i_ack || d_ack)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=i_ack:%0b,d_ack:%0b required=none (cycle %0d)",
                         i_ack, d_ack, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_kind", {31'd0, d_ack}, {31'd0, e.is_data});
                check("ack_both", {31'd0, i_ack & d_ack}, 32'd0);
                check("ack_cycle", cyc, e.cyc);
                if (e.chk_data) begin
                    check(e.is_data ? "d_rdata" : "i_data", e.is_data ? d_rdata : i_data, e.data);
                end
                $display("ack %s at cycle %0d data=%h", e.is_data ? "data " : "fetch", cyc,
                         e.is_data ? d_rdata : i_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        // Reset state
        step();
        step();
        rst = 1'b0;
        at_neg();
        check("rst_bus_read", {31'd0, bus_read}, 32'd0);
        check("rst_bus_write", {31'd0, bus_write}, 32'd0);
        check("rst_i_data", i_data, 32'h0000_0013);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        // Zero-wait fetch
        step();
        i_req = 1'b1; i_addr = 32'h4; bus_rdata = 32'h3e80_0093; bus_busy = 1'b0;
        c = cyc;
        expect_ack(1'b0, 1'b1, 32'h3e80_0093, c + 2);
        $display("txn fetch addr=%h issued at cycle %0d", i_addr, c);
        step(); at_neg();
        check("f_bus_read", {31'd0, bus_read}, 32'd1);
        check("f_bus_addr", bus_addr, 32'h4);
        check("f_bus_sel", {28'd0, bus_sel}, 32'hF);
        check("f_stall", {31'd0, stall}, 32'd1);
        step(); at_neg();
        check("f_stall_ack", {31'd0, stall}, 32'd0);
        step(); i_req = 1'b0;
        at_neg();
        check("f_idle_read", {31'd0, bus_read}, 32'd0);
        check("f_i_data_held", i_data, 32'h3e80_0093);

        // Simultaneous fetch and load: load first
        step();
        i_req = 1'b1; i_addr = 32'h8;
        d_read = 1'b1; d_addr = 32'h100; d_sel = 4'hF; bus_rdata = 32'd1000;
        c = cyc;
        expect_ack(1'b1, 1'b1, 32'd1000, c + 2);
        expect_ack(1'b0, 1'b1, 32'd1000, c + 5);
        $display("txn load addr=%h + fetch addr=%h issued at cycle %0d", d_addr, i_addr, c);
        step(); at_neg();
        check("s_bus_addr_d", bus_addr, 32'h100);
        check("s_bus_read_d", {31'd0, bus_read}, 32'd1);
        step();
        step(); d_read = 1'b0;
        at_neg();
        check("s_idle_read", {31'd0, bus_read}, 32'd0);
        check("s_stall_fetch", {31'd0, stall}, 32'd1);
        step(); at_neg();
        check("s_bus_addr_f", bus_addr, 32'h8);
        check("s_bus_sel_f", {28'd0, bus_sel}, 32'hF);
        step();
        step(); i_req = 1'b0;

        // Store with three wait states
        step();
        d_write = 1'b1; d_addr = 32'h8; d_wdata = 32'hCAFE; d_sel = 4'b0011; bus_busy = 1'b1;
        c = cyc;
        expect_ack(1'b1, 1'b0, 32'd0, c + 5);
        $display("txn store addr=%h data=%h issued at cycle %0d", d_addr, d_wdata, c);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) bus_busy = 1'b0;
            at_neg();
            check("w_bus_write", {31'd0, bus_write}, 32'd1);
            check("w_bus_read", {31'd0, bus_read}, 32'd0);
            check("w_stall", {31'd0, stall}, 32'd1);
            if (k == 1) begin
                check("w_bus_addr", bus_addr, 32'h8);
                check("w_bus_wdata", bus_wdata, 32'hCAFE);
                check("w_bus_sel", {28'd0, bus_sel}, 32'h3);
            end
        end
        step(); at_neg();
        check("w_bus_write_done", {31'd0, bus_write}, 32'd0);
        check("w_stall_ack", {31'd0, stall}, 32'd0);
        step(); d_write = 1'b0;

        // Fetch request dropped after grant
        step();
        i_req = 1'b1; i_addr = 32'hC; bus_rdata = 32'h00a0_0113; bus_busy = 1'b1;
        c = cyc;
        expect_ack(1'b0, 1'b1, 32'h00a0_0113, c + 3);
        $display("txn fetch addr=%h (dropped) issued at cycle %0d", i_addr, c);
        step(); i_req = 1'b0;
        at_neg();
        check("x_bus_read", {31'd0, bus_read}, 32'd1);
        check("x_stall", {31'd0, stall}, 32'd0);
        step(); bus_busy = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            step(); at_neg();
            check("x_no_reissue", {31'd0, bus_read}, 32'd0);
        end

`ifdef ARB_TIMEOUT_EN
        // Fetch that never completes
        step();
        i_req = 1'b1; i_addr = 32'h10; bus_rdata = 32'hDEAD_BEEF; bus_busy = 1'b1;
        c = cyc;
        expect_ack(1'b0, 1'b1, 32'h0000_0013, c + 5);
        $display("txn fetch addr=%h (timeout) issued at cycle %0d", i_addr, c);
        for (int k = 1; k <= 4; k++) begin
            step(); at_neg();
            check("t_bus_read", {31'd0, bus_read}, 32'd1);
        end
        step(); at_neg();
        check("t_bus_read_drop", {31'd0, bus_read}, 32'd0);
        check("t_err", {31'd0, err}, 32'd1);
        step(); i_req = 1'b0; bus_busy = 1'b0;
        step(); at_neg();
        check("t_err_sticky", {31'd0, err}, 32'd1);
`else
        at_neg();
        check("err_tied", {31'd0, err}, 32'd0);
`endif

        // Reset in the middle of a busy load
        step();
        d_read = 1'b1; d_addr = 32'h20; d_sel = 4'hF; bus_busy = 1'b1;
        $display("txn load addr=%h (reset abort) issued at cycle %0d", d_addr, cyc);
        step(); at_neg();
        check("r_bus_read", {31'd0, bus_read}, 32'd1);
        step(); rst = 1'b1;
        at_neg();
        check("r_bus_read0", {31'd0, bus_read}, 32'd0);
        check("r_bus_write0", {31'd0, bus_write}, 32'd0);
        check("r_bus_addr0", bus_addr, 32'd0);
        check("r_i_data_nop", i_data, 32'h0000_0013);
        check("r_d_rdata0", d_rdata, 32'd0);
        check("r_err0", {31'd0, err}, 32'd0);
        check("r_stall_req", {31'd0, stall}, 32'd1);
        d_read = 1'b0;
        #1;
        check("r_stall_noreq", {31'd0, stall}, 32'd0);
        step(); rst = 1'b0; bus_busy = 1'b0;

        // Recovery: zero-wait load after reset
        step();
        d_read = 1'b1; d_addr = 32'h24; bus_rdata = 32'd5;
        c = cyc;
        expect_ack(1'b1, 1'b1, 32'd5, c + 2);
        $display("txn load addr=%h issued at cycle %0d", d_addr, c);
        step(); at_neg();
        check("v_bus_addr", bus_addr, 32'h24);
        step();
        step(); d_read = 1'b0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("pending_acks", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares the single memory port between instruction fetch and the load/store datapath of the single-cycle RV32I core. It accepts a fetch request (PC stage) and a data request (memRead/memWrite path), grants one at a time, drives the memory bus, and returns the instruction word or load data with a one-cycle acknowledge. It drives a stall signal that freezes PC and register writeback while any accepted request is still outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max busy cycles per transaction (used only with ARB_TIMEOUT_EN)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  ADDR_W  fetch address (PC)
- i_ack  out  1  one-cycle pulse, i_data valid
- i_data  out  DATA_W  fetched instruction, held until next i_ack
- d_read  in  1  load request, level, held until d_ack
- d_write  in  1  store request, level, held until d_ack
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_sel  in  4  byte enables
- d_ack  out  1  one-cycle pulse, access complete
- d_rdata  out  DATA_W  load data, held until next d_ack
- bus_read, bus_write  out  1  memory command, registered
- bus_addr  out  ADDR_W  registered
- bus_wdata  out  DATA_W  registered
- bus_sel  out  4  registered; 4'hF for fetches
- bus_rdata  in  DATA_W  read data, valid when bus_busy low
- bus_busy  in  1  memory not ready
- stall  out  1  combinational freeze to core
- err  out  1  sticky timeout flag

## Operation
- FSM: IDLE, FETCH, DATA, DONE.
- IDLE: if d_read|d_write -> DATA; else if i_req -> FETCH. Data has fixed priority (belongs to the instruction in flight). Address/data/sel latched on the grant edge.
- FETCH/DATA: bus_read (or bus_write for store) held with latched address; transaction completes on the first edge in the state with bus_busy=0; read data captured into i_data/d_rdata on that edge; -> DONE.
- d_read and d_write both high: treated as store; read ignored.
- DONE: matching ack high for exactly this cycle, all bus commands low; -> IDLE. The requester drops its request on the edge ending DONE, so no re-issue.
- Request dropped mid-transaction: transaction still completes and acks.
- stall = (i_req & ~i_ack) | ((d_read|d_write) & ~d_ack).
- Reset (any time, including mid-transaction): state IDLE; all bus outputs, acks, err = 0; i_data = 32'h00000013 (NOP); d_rdata = 0. Aborted transaction is not resumed.

## Timing
- Request sampled at edge N -> bus command asserted after N+1 -> with bus_busy=0, ack high in cycle after N+2. Minimum latency 2 cycles; each busy cycle adds 1.
- Throughput: one transaction per 3 cycles minimum (grant, access, DONE).
- Fetch+data pending together: data granted first; fetch granted in IDLE after data's DONE (3 cycles later, zero-wait).
- Bus outputs change only on clock edges; stall is the only combinational output.

## Configuration
- ARB_TIMEOUT_EN defined: 8-bit-wide-or-more counter clears on grant, increments each FETCH/DATA cycle with bus_busy=1; on reaching TIMEOUT, bus command drops, FSM -> DONE, ack pulses with i_data = 32'h00000013 or d_rdata = 0, err set and held until rst.
- Not defined: no counter; FETCH/DATA wait indefinitely; err tied 0.

## Test plan
- Reset: rst high mid-DATA with bus_busy=1 -> next cycle all bus outputs 0, i_data=32'h00000013, stall follows request inputs only.
- Zero-wait fetch: i_req=1, i_addr=32'h4, bus_rdata=32'h3e800093 -> bus_read high 1 cycle later with bus_addr=32'h4, i_ack pulse 2 cycles after request, i_data=32'h3e800093.
- Simultaneous: i_req and d_read (d_addr=32'h100, bus_rdata=32'd1000) same cycle -> load served first, d_rdata=1000, d_ack; then fetch, i_ack 3 cycles after d_ack.
- Wait states: store d_addr=32'h8, d_wdata=32'hCAFE, d_sel=4'b0011, bus_busy high 3 cycles -> bus_write held 4 cycles, d_ack 5 cycles after request, stall high until d_ack.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): fetch with bus_busy stuck high -> bus_read drops after 4 busy cycles, i_ack with i_data=32'h00000013, err=1 until rst.
- Dropped request: i_req deasserted one cycle after grant -> bus transaction completes, i_ack still pulses once, no second bus_read.
